// File: rtl/axi_burst_responder_if.sv
// axi_burst_responder_if: AXI4-style read/write burst channels between an initiator and the responder
interface axi_burst_responder_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arlen, arvalid, rready,
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arlen, arvalid, rready,
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_burst_responder.sv
// axi_burst_responder: word-memory AXI slave serving INCR read bursts on R and absorbing write bursts on W
module axi_burst_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = 10
) (
  input logic               clk,
  input logic               rstn,
  axi_burst_responder_if.slave bus
);
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [31:0] mem [MEM_WORDS];

  r_state_t         r_state_q, r_state_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [7:0]       rcnt_q, rcnt_d;

  w_state_t         w_state_q, w_state_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             mem_we;

  logic [IDX_W-1:0] ar_idx, aw_idx, ridx_nx;
  logic             unused_addr_bits;

  assign ar_idx  = bus.araddr[IDX_W+1:2];
  assign aw_idx  = bus.awaddr[IDX_W+1:2];
  assign ridx_nx = ridx_q + 1'b1;
  assign unused_addr_bits = ^{bus.araddr[31:IDX_W+2], bus.araddr[1:0],
                              bus.awaddr[31:IDX_W+2], bus.awaddr[1:0]};

  // read channel: accept AR, then stream beats; the next beat is loaded on each accepted beat
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    ridx_d    = ridx_q;
    rcnt_d    = rcnt_q;
    if (r_state_q == R_IDLE) begin
      arready_d = 1'b1;
      if (arready_q && bus.arvalid) begin
        r_state_d = R_BURST;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        ridx_d    = ar_idx;
        rcnt_d    = bus.arlen;
        rdata_d   = mem[ar_idx];
        rlast_d   = (bus.arlen == 8'd0);
      end
    end else if (bus.rready) begin
      if (rcnt_q == 8'd0) begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        arready_d = 1'b1;
      end else begin
        ridx_d  = ridx_nx;
        rcnt_d  = rcnt_q - 8'd1;
        rdata_d = mem[ridx_nx];
        rlast_d = (rcnt_q == 8'd1);
      end
    end
  end

  // write channel: accept AW, take beats until count or wlast ends the burst, then hold B
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    widx_d    = widx_q;
    wcnt_d    = wcnt_q;
    mem_we    = 1'b0;
    if (w_state_q == W_IDLE) begin
      awready_d = 1'b1;
      if (awready_q && bus.awvalid) begin
        w_state_d = W_DATA;
        awready_d = 1'b0;
        wready_d  = 1'b1;
        widx_d    = aw_idx;
        wcnt_d    = bus.awlen;
      end
    end else if (w_state_q == W_DATA) begin
      if (bus.wvalid && wready_q) begin
        mem_we = 1'b1;
        if (wcnt_q == 8'd0 || bus.wlast) begin
          w_state_d = W_RESP;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = (wcnt_q == 8'd0 && bus.wlast) ? OKAY : SLVERR;
        end else begin
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q - 8'd1;
        end
      end
    end else if (bus.bready) begin
      w_state_d = W_IDLE;
      bvalid_d  = 1'b0;
      awready_d = 1'b1;
    end
  end

  // state and registered outputs for both channels; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      widx_q    <= '0;
      wcnt_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      ridx_q    <= ridx_d;
      rcnt_q    <= rcnt_d;
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // byte-masked memory write; contents survive reset, and a same-cycle read sees the old word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we && bus.wstrb[i]) mem[widx_q][8*i +: 8] <= bus.wdata[8*i +: 8];
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = OKAY;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
endmodule
